// File: rtl/fifo_write_skid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_skid_pkg
// Description : Shared DMA constants and types. DMA_DATA_W is the common data
//               word width, also used by the read-side FWFT logic. occ_e
//               encodes the occupancy of the 2-entry write skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_write_skid_pkg;

  localparam int DMA_DATA_W = 32;

  // Buffer occupancy: number of words currently held (0, 1 or 2).
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage : fifo_write_skid_pkg
`default_nettype wire

// File: rtl/fifo_write_skid.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_skid
// Description : Write-side front end for the DMA data FIFO. Takes words from
//               a producer over valid/ready, holds up to two in a skid buffer
//               and writes the oldest to the FIFO whenever it is not full.
//               wr_ready comes straight from a flop so full_fifo never reaches
//               the producer combinationally. Counts committed FIFO writes.
// Ports       : wclk           - write-domain clock
//               wrst           - asynchronous active-high reset
//               wr_valid       - producer word present
//               wr_data        - producer word
//               wr_ready       - registered; block can take a word
//               full_fifo      - FIFO full flag
//               wr_enable_fifo - FIFO write strobe
//               wr_data_fifo   - oldest buffered word (FIFO write data)
//               words_written  - FIFO writes since reset, wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_skid
  import fifo_write_skid_pkg::*;
#(
  parameter int DATA_W = DMA_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              full_fifo,
  output logic              wr_enable_fifo,
  output logic [DATA_W-1:0] wr_data_fifo,
  output logic [CNT_W-1:0]  words_written
);

  occ_e              occ_q,   occ_d;
  logic [DATA_W-1:0] head_q,  head_d;
  logic [DATA_W-1:0] tail_q,  tail_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  words_q, words_d;

  logic w_accept;
  logic w_drain;

  assign w_accept = wr_valid & ready_q;
  assign w_drain  = (occ_q != OCC_EMPTY) & ~full_fifo;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      occ_q   <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
      words_q <= '0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= ready_d;
      words_q <= words_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;

    case (occ_q)
      OCC_EMPTY: begin
        if (w_accept) begin
          head_d = wr_data;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({w_accept, w_drain})
          2'b10: begin
            tail_d = wr_data;
            occ_d  = OCC_TWO;
          end
          2'b01: begin
            occ_d  = OCC_EMPTY;
          end
          // Head leaves and the new word replaces it in the same edge.
          2'b11: begin
            head_d = wr_data;
          end
          default: begin
            occ_d  = OCC_ONE;
          end
        endcase
      end
      OCC_TWO: begin
        // wr_ready is low here, so only a drain can happen.
        if (w_drain) begin
          head_d = tail_q;
          occ_d  = OCC_ONE;
        end
      end
      default: begin
        occ_d = OCC_EMPTY;
      end
    endcase

    // Registered ready reflects the occupancy that will exist after this edge.
    ready_d = (occ_d != OCC_TWO);
    words_d = words_q + {{(CNT_W-1){1'b0}}, w_drain};
  end

  assign wr_ready       = ready_q;
  assign wr_enable_fifo = w_drain;
  assign wr_data_fifo   = head_q;
  assign words_written  = words_q;

endmodule : fifo_write_skid
`default_nettype wire

// File: tb/tb_fifo_write_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_skid
// Description : Directed self-checking bench for fifo_write_skid. A second
//               instance with a 4-bit counter shares the stimulus so the
//               counter wrap can be observed.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_skid;

  localparam int DW = 32;

  logic          wclk = 1'b0;
  logic          wrst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full_fifo = 1'b0;
  logic          wr_ready;
  logic          wr_enable_fifo;
  logic [DW-1:0] wr_data_fifo;
  logic [15:0]   words_written;
  logic          wr_ready4;
  logic          wr_enable_fifo4;
  logic [DW-1:0] wr_data_fifo4;
  logic [3:0]    words_written4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 wclk = ~wclk;

  fifo_write_skid #(.DATA_W(DW), .CNT_W(16)) u_dut (
    .wclk(wclk), .wrst(wrst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .full_fifo(full_fifo), .wr_enable_fifo(wr_enable_fifo),
    .wr_data_fifo(wr_data_fifo), .words_written(words_written)
  );

  fifo_write_skid #(.DATA_W(DW), .CNT_W(4)) u_dut4 (
    .wclk(wclk), .wrst(wrst), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready4), .full_fifo(full_fifo), .wr_enable_fifo(wr_enable_fifo4),
    .wr_data_fifo(wr_data_fifo4), .words_written(words_written4)
  );

  // Advance one edge, then apply inputs for the new cycle; outputs are
  // stable and sampled 2 time units after the edge.
  task automatic drive(input logic v, input logic [DW-1:0] d, input logic f);
    @(posedge wclk);
    #1;
    wr_valid  = v;
    wr_data   = d;
    full_fifo = f;
    #1;
  endtask

  task automatic apply_reset();
    @(posedge wclk);
    #1;
    wrst      = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = '0;
    full_fifo = 1'b0;
    repeat (2) @(posedge wclk);
    #1;
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    wrst = 1'b1;
    repeat (3) @(posedge wclk);
    #2;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", wr_ready); end
    n_checks++;
    if (wr_enable_fifo !== 1'b0) begin n_fail++; $display("FAIL reset_wen got=%b exp=0", wr_enable_fifo); end
    n_checks++;
    if (wr_data_fifo !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", wr_data_fifo); end
    n_checks++;
    if (words_written !== 16'h0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", words_written); end
    wrst = 1'b0;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL release_ready_early got=%b exp=0", wr_ready); end
    @(posedge wclk);
    #1;
    n_checks++;
    if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL release_ready got=%b exp=1", wr_ready); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      drive(k < 4, 32'hA0 + k, 1'b0);
      n_checks++;
      if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready cyc=%0d got=%b exp=1", k, wr_ready); end
      n_checks++;
      if (wr_enable_fifo !== (k >= 1)) begin n_fail++; $display("FAIL b2b_wen cyc=%0d got=%b exp=%b", k, wr_enable_fifo, k >= 1); end
      if (k >= 1) begin
        n_checks++;
        if (wr_data_fifo !== 32'hA0 + k - 1) begin n_fail++; $display("FAIL b2b_data cyc=%0d got=%h exp=%h", k, wr_data_fifo, 32'hA0 + k - 1); end
      end
    end
    drive(1'b0, '0, 1'b0);
    n_checks++;
    if (wr_enable_fifo !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got=%b exp=0", wr_enable_fifo); end
    n_checks++;
    if (words_written !== 16'd4) begin n_fail++; $display("FAIL b2b_count got=%0d exp=4", words_written); end
  endtask

  task automatic test_full_stall();
    apply_reset();
    drive(1'b1, 32'hB0, 1'b1);
    n_checks++;
    if (wr_ready !== 1'b1 || wr_enable_fifo !== 1'b0) begin n_fail++; $display("FAIL stall_c0 got rdy=%b wen=%b exp rdy=1 wen=0", wr_ready, wr_enable_fifo); end
    drive(1'b1, 32'hB1, 1'b1);
    n_checks++;
    if (wr_ready !== 1'b1 || wr_data_fifo !== 32'hB0) begin n_fail++; $display("FAIL stall_c1 got rdy=%b data=%h exp rdy=1 data=b0", wr_ready, wr_data_fifo); end
    drive(1'b1, 32'hB2, 1'b1);
    n_checks++;
    if (wr_ready !== 1'b0 || wr_enable_fifo !== 1'b0) begin n_fail++; $display("FAIL stall_full got rdy=%b wen=%b exp rdy=0 wen=0", wr_ready, wr_enable_fifo); end
    drive(1'b1, 32'hB2, 1'b1);
    n_checks++;
    if (wr_ready !== 1'b0 || wr_data_fifo !== 32'hB0) begin n_fail++; $display("FAIL stall_hold got rdy=%b data=%h exp rdy=0 data=b0", wr_ready, wr_data_fifo); end
    drive(1'b1, 32'hB2, 1'b0);
    n_checks++;
    if (wr_enable_fifo !== 1'b1 || wr_data_fifo !== 32'hB0 || wr_ready !== 1'b0) begin n_fail++; $display("FAIL stall_rel0 got wen=%b data=%h rdy=%b exp wen=1 data=b0 rdy=0", wr_enable_fifo, wr_data_fifo, wr_ready); end
    drive(1'b1, 32'hB2, 1'b0);
    n_checks++;
    if (wr_enable_fifo !== 1'b1 || wr_data_fifo !== 32'hB1 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL stall_rel1 got wen=%b data=%h rdy=%b exp wen=1 data=b1 rdy=1", wr_enable_fifo, wr_data_fifo, wr_ready); end
    drive(1'b0, '0, 1'b0);
    n_checks++;
    if (wr_enable_fifo !== 1'b1 || wr_data_fifo !== 32'hB2) begin n_fail++; $display("FAIL stall_rel2 got wen=%b data=%h exp wen=1 data=b2", wr_enable_fifo, wr_data_fifo); end
    drive(1'b0, '0, 1'b0);
    n_checks++;
    if (wr_enable_fifo !== 1'b0 || words_written !== 16'd3) begin n_fail++; $display("FAIL stall_end got wen=%b cnt=%0d exp wen=0 cnt=3", wr_enable_fifo, words_written); end
  endtask

  task automatic test_alternate_full();
    int p;
    int r;
    int cyc;
    apply_reset();
    p = 0;
    r = 0;
    cyc = 0;
    while (r < 16 && cyc < 100) begin
      drive(p < 16, p, cyc[0]);
      n_checks++;
      if (wr_enable_fifo && full_fifo) begin n_fail++; $display("FAIL alt_wen_while_full cyc=%0d got=1 exp=0", cyc); end
      if (wr_enable_fifo) begin
        n_checks++;
        if (wr_data_fifo !== r) begin n_fail++; $display("FAIL alt_order cyc=%0d got=%h exp=%h", cyc, wr_data_fifo, r); end
        r++;
      end
      if (wr_valid && wr_ready) p++;
      cyc++;
    end
    drive(1'b0, '0, 1'b0);
    n_checks++;
    if (r !== 16) begin n_fail++; $display("FAIL alt_timeout got=%0d exp=16 words", r); end
    n_checks++;
    if (words_written !== 16'd16 || wr_enable_fifo !== 1'b0) begin n_fail++; $display("FAIL alt_count got cnt=%0d wen=%b exp cnt=16 wen=0", words_written, wr_enable_fifo); end
  endtask

  task automatic test_accept_drain();
    apply_reset();
    drive(1'b1, 32'hC0, 1'b0);
    drive(1'b1, 32'hC1, 1'b0);
    n_checks++;
    if (wr_enable_fifo !== 1'b1 || wr_data_fifo !== 32'hC0) begin n_fail++; $display("FAIL ad_first got wen=%b data=%h exp wen=1 data=c0", wr_enable_fifo, wr_data_fifo); end
    drive(1'b0, '0, 1'b1);
    n_checks++;
    if (wr_data_fifo !== 32'hC1 || wr_ready !== 1'b1 || wr_enable_fifo !== 1'b0) begin n_fail++; $display("FAIL ad_new got data=%h rdy=%b wen=%b exp data=c1 rdy=1 wen=0", wr_data_fifo, wr_ready, wr_enable_fifo); end
    drive(1'b0, '0, 1'b1);
    n_checks++;
    if (wr_data_fifo !== 32'hC1 || wr_ready !== 1'b1) begin n_fail++; $display("FAIL ad_count1 got data=%h rdy=%b exp data=c1 rdy=1", wr_data_fifo, wr_ready); end
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    n_checks++;
    if (wr_enable_fifo !== 1'b0 || words_written !== 16'd2) begin n_fail++; $display("FAIL ad_end got wen=%b cnt=%0d exp wen=0 cnt=2", wr_enable_fifo, words_written); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_cnt [3];
    exp_cnt[0] = 4'd15;
    exp_cnt[1] = 4'd0;
    exp_cnt[2] = 4'd1;
    apply_reset();
    for (int i = 0; i < 14; i++) drive(1'b1, i, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b0, '0, 1'b0);
    n_checks++;
    if (words_written4 !== 4'd14) begin n_fail++; $display("FAIL wrap_pre got=%0d exp=14", words_written4); end
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 32'h50 + j, 1'b0);
      drive(1'b0, '0, 1'b0);
      drive(1'b0, '0, 1'b0);
      n_checks++;
      if (words_written4 !== exp_cnt[j]) begin n_fail++; $display("FAIL wrap_step%0d got=%0d exp=%0d", j, words_written4, exp_cnt[j]); end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive(1'b1, 32'hE0, 1'b0);
    drive(1'b0, '0, 1'b0);
    drive(1'b1, 32'hD0, 1'b1);
    drive(1'b1, 32'hD1, 1'b1);
    drive(1'b0, '0, 1'b1);
    n_checks++;
    if (wr_ready !== 1'b0 || words_written !== 16'd1) begin n_fail++; $display("FAIL mid_pre got rdy=%b cnt=%0d exp rdy=0 cnt=1", wr_ready, words_written); end
    wrst      = 1'b1;
    full_fifo = 1'b0;
    #1;
    n_checks++;
    if (wr_enable_fifo !== 1'b0 || wr_ready !== 1'b0 || words_written !== 16'd0) begin n_fail++; $display("FAIL mid_reset got wen=%b rdy=%b cnt=%0d exp wen=0 rdy=0 cnt=0", wr_enable_fifo, wr_ready, words_written); end
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, '0, 1'b0);
      n_checks++;
      if (wr_enable_fifo !== 1'b0) begin n_fail++; $display("FAIL mid_stale cyc=%0d got wen=%b data=%h exp wen=0", k, wr_enable_fifo, wr_data_fifo); end
    end
    n_checks++;
    if (words_written !== 16'd0) begin n_fail++; $display("FAIL mid_count got=%0d exp=0", words_written); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_stall();
    test_alternate_full();
    test_accept_drain();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_write_skid
`default_nettype wire
